decode_queue: RTL and testbench

Parametrised, buffered successor to the combinational instruction decoder. It accepts 16-bit instructions over a valid/ready handshake and decodes them into all fields at once: Rn, Rd and Rm in parallel, so no nsel sequencing is needed. It also produces W-bit sign-extended immediates, branch and illegal-instruction flags, and stores the results in a DEPTH-entry FIFO. It sits between the instruction register and the controller FSM/datapath, so instruction fetch can run ahead of execution.

---
 rtl/decode_queue.sv | 144 ++++++++++++++
 tb/tb_decode_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
//------------------------------------------------------------------------------
// decode_queue: decodes 16-bit instructions at push into a DEPTH-entry FIFO of
// decoded fields (Rn/Rd/Rm, sign-extended immediates, branch/illegal flags).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decode_queue #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_opcode,
    output logic [1:0]               out_op,
    output logic [1:0]               out_aluop,
    output logic [2:0]               out_rn,
    output logic [2:0]               out_rd,
    output logic [2:0]               out_rm,
    output logic [1:0]               out_shift,
    output logic [2:0]               out_cond,
    output logic [W-1:0]             out_sximm5,
    output logic [W-1:0]             out_sximm8,
    output logic                     out_is_branch,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               illegal_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [2:0]   opcode;
        logic [1:0]   op;
        logic [2:0]   rn;
        logic [2:0]   rd;
        logic [2:0]   rm;
        logic [1:0]   shift;
        logic [2:0]   cond;
        logic [W-1:0] sximm5;
        logic [W-1:0] sximm8;
        logic         is_branch;
        logic         illegal;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        dec;
    entry_t        head;
    logic          legal;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        dec           = '0;
        legal         = 1'b0;
        dec.opcode    = in_instr[15:13];
        dec.op        = in_instr[12:11];
        dec.rn        = in_instr[10:8];
        dec.rd        = in_instr[7:5];
        dec.shift     = in_instr[4:3];
        dec.rm        = in_instr[2:0];
        dec.sximm5    = W'($signed(in_instr[4:0]));
        dec.sximm8    = W'($signed(in_instr[7:0]));
        dec.is_branch = (in_instr[15:13] == 3'b001) || (in_instr[15:13] == 3'b010);
        dec.cond      = dec.is_branch ? in_instr[10:8] : 3'b000;
        case (in_instr[15:13])
            3'b110:                legal = (in_instr[11] == 1'b0);
            3'b101:                legal = 1'b1;
            3'b011, 3'b100, 3'b111: legal = (in_instr[12:11] == 2'b00);
            3'b001:                legal = (in_instr[10:8] <= 3'b100);
            3'b010:                legal = (in_instr[12:11] != 2'b01);
            default:               legal = 1'b0;
        endcase
        dec.illegal   = !legal;
    end

    // Storage has no reset: entries are only visible through the out_valid gate.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= dec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (dec.illegal && (illegal_cnt != 8'hFF)) begin
                    illegal_cnt <= illegal_cnt + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_opcode    = head.opcode;
    assign out_op        = head.op;
    assign out_aluop     = head.op;
    assign out_rn        = head.rn;
    assign out_rd        = head.rd;
    assign out_rm        = head.rm;
    assign out_shift     = head.shift;
    assign out_cond      = head.cond;
    assign out_sximm5    = head.sximm5;
    assign out_sximm8    = head.sximm8;
    assign out_is_branch = head.is_branch;
    assign out_illegal   = head.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
//------------------------------------------------------------------------------
// tb_decode_queue: directed vectors against a W=16 and a W=32 instance driven
// by identical stimulus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode_queue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_is_branch, out_illegal;
    logic [2:0]  out_opcode, out_rn, out_rd, out_rm, out_cond;
    logic [1:0]  out_op, out_aluop, out_shift, count;
    logic [15:0] out_sximm5, out_sximm8;
    logic [7:0]  illegal_cnt;

    logic        x_in_ready, x_out_valid, x_out_is_branch, x_out_illegal;
    logic [2:0]  x_out_opcode, x_out_rn, x_out_rd, x_out_rm, x_out_cond;
    logic [1:0]  x_out_op, x_out_aluop, x_out_shift, x_count;
    logic [31:0] x_out_sximm5, x_out_sximm8;
    logic [7:0]  x_illegal_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decode_queue #(.W(16), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_op(out_op), .out_aluop(out_aluop), .out_rn(out_rn),
        .out_rd(out_rd), .out_rm(out_rm), .out_shift(out_shift), .out_cond(out_cond),
        .out_sximm5(out_sximm5), .out_sximm8(out_sximm8), .out_is_branch(out_is_branch),
        .out_illegal(out_illegal), .count(count), .illegal_cnt(illegal_cnt)
    );

    decode_queue #(.W(32), .DEPTH(2)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(x_in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(x_out_valid), .out_ready(out_ready),
        .out_opcode(x_out_opcode), .out_op(x_out_op), .out_aluop(x_out_aluop), .out_rn(x_out_rn),
        .out_rd(x_out_rd), .out_rm(x_out_rm), .out_shift(x_out_shift), .out_cond(x_out_cond),
        .out_sximm5(x_out_sximm5), .out_sximm8(x_out_sximm8), .out_is_branch(x_out_is_branch),
        .out_illegal(x_out_illegal), .count(x_count), .illegal_cnt(x_illegal_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // {instr, expected illegal}
    logic [16:0] legal_tab [10] = '{
        {16'h6000, 1'b0}, {16'h6800, 1'b1}, {16'h5000, 1'b0}, {16'h4800, 1'b1},
        {16'hC800, 1'b1}, {16'h2400, 1'b0}, {16'hB800, 1'b0}, {16'hE000, 1'b0},
        {16'h8800, 1'b1}, {16'h5800, 1'b0}
    };

    initial begin
        int pushed, popped, bad, cyc;
        logic [16:0] ent;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_illegal_cnt", illegal_cnt, 0);
        check("rst_opcode", out_opcode, 0);
        check("rst_sximm8", out_sximm8, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // MOV R1,#5 with no same-cycle fall-through
        in_valid = 1'b1;
        in_instr = 16'hD105;
        #1;
        check("no_fallthrough", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mov_valid", out_valid, 1);
        check("mov_opcode", out_opcode, 3'b110);
        check("mov_op", out_op, 2'b10);
        check("mov_aluop", out_aluop, 2'b10);
        check("mov_rn", out_rn, 3'b001);
        check("mov_sximm8", out_sximm8, 16'h0005);
        check("mov_illegal", out_illegal, 0);
        check("mov_count", count, 1);
        pop();
        check("drain_count", count, 0);
        check("drain_zero_fields", {out_opcode, out_rn, out_sximm8}, 0);

        // Fill with out_ready held low
        push(16'hA3F4);
        check("a3f4_rm", out_rm, 3'b100);
        check("a3f4_rd", out_rd, 3'b111);
        check("a3f4_shift", out_shift, 2'b10);
        check("a3f4_sximm5", out_sximm5, 16'hFFF4);
        check("a3f4_sximm5_w32", x_out_sximm5, 32'hFFFFFFF4);
        push(16'hD2FF);
        check("full_count", count, 2);
        check("full_in_ready", in_ready, 0);
        check("full_head_stable", out_rm, 3'b100);
        push(16'h0000);
        check("refused_count", count, 2);
        check("refused_not_counted", illegal_cnt, 0);
        pop();
        check("pop1_in_ready", in_ready, 1);
        check("pop1_count", count, 1);
        check("pop1_sximm8", out_sximm8, 16'hFFFF);
        check("pop1_opcode", out_opcode, 3'b110);
        pop();
        check("pop2_count", count, 0);

        // Branch, W=32 sign extension
        push(16'h21FE);
        check("br_is_branch", out_is_branch, 1);
        check("br_cond", out_cond, 3'b001);
        check("br_illegal", out_illegal, 0);
        check("br_sximm8", out_sximm8, 16'hFFFE);
        check("br_sximm8_w32", x_out_sximm8, 32'hFFFFFFFE);
        pop();

        // Two illegal encodings
        push(16'h0000);
        push(16'h2700);
        check("ill0_illegal", out_illegal, 1);
        check("ill0_is_branch", out_is_branch, 0);
        check("ill_cnt_2", illegal_cnt, 2);
        pop();
        check("ill1_illegal", out_illegal, 1);
        check("ill1_cond", out_cond, 3'b111);
        check("ill1_count", count, 1);

        // Flush beats simultaneous push and pop
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 16'h0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_illegal_cnt", illegal_cnt, 2);

        // Legality table
        for (int i = 0; i < 10; i++) begin
            ent = legal_tab[i];
            push(ent[16:1]);
            check($sformatf("legal_tab_%0d", i), out_illegal, ent[0]);
            pop();
        end
        check("legal_tab_illegal_cnt", illegal_cnt, 6);

        // Stream 300 illegal words, consumer always ready
        pushed = 0; popped = 0; bad = 0; cyc = 0;
        out_ready = 1'b1;
        while ((pushed < 300 || popped < pushed) && cyc < 2000) begin
            in_valid = (pushed < 300);
            in_instr = {3'b000, pushed[12:0]};
            #1;
            if (out_valid) begin
                if (out_illegal !== 1'b1 || out_rm !== popped[2:0] || out_rd !== popped[7:5])
                    bad++;
                popped++;
            end
            if (in_valid && in_ready) pushed++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("stream_timeout", cyc < 2000, 1);
        check("stream_popped", popped, 300);
        check("stream_order", bad, 0);
        check("stream_illegal_sat", illegal_cnt, 255);
        check("stream_count", count, 0);

        // Asynchronous reset mid-transfer
        push(16'hD105);
        in_valid = 1'b1;
        in_instr = 16'hA3F4;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_opcode", out_opcode, 0);
        check("arst_illegal_cnt", illegal_cnt, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("arst_hold_count", count, 0);
        check("arst_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
